dual_stall_pipeline: RTL and testbench
======================================

DUAL_STALL_PIPELINE -- requirements
Module: dual_stall_pipeline

Interface
REQ-001 The block SHALL expose the parameter DATA_W, default 32, as the lane data width.
REQ-002 The block SHALL expose the parameter STAGES, default 4, as the number of pipeline stages per lane (legal 2..8).
REQ-003 The block SHALL expose the parameter FIFO_DEPTH, default 4, as the output FIFO entries per lane (power of 2, 2..16).
REQ-004 The port clk SHALL be an input, 1 bit wide: the single clock.
REQ-005 The port reset_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-006 The port pipeline1_inputs SHALL be an input, DATA_W bits wide: lane 1 data.
REQ-007 The port pipeline2_inputs SHALL be an input, DATA_W bits wide: lane 2 data.
REQ-008 The port in_valid SHALL be an input, 2 bits wide: bit0 is lane 1 valid, bit1 is lane 2 valid.
REQ-009 The ports flush_1 and flush_2 SHALL be inputs, 1 bit each: per-lane flush.
REQ-010 The ports stall_1 and stall_2 SHALL be outputs, 1 bit each: per-lane back-pressure to the upstream source.
REQ-011 The ports out_valid_1 and out_valid_2 SHALL be outputs, 1 bit each: the lane FIFO is non-empty.
REQ-012 The ports out_data_1 and out_data_2 SHALL be outputs, DATA_W bits each: the lane FIFO head.
REQ-013 The ports out_ready_1 and out_ready_2 SHALL be inputs, 1 bit each: downstream pops the head.

Function (per lane, lanes fully independent)
REQ-014 Each stage SHALL be a valid+data register pair; stage k output SHALL be stage k input + 1, modulo 2^DATA_W, so out_data = in_data + STAGES (wraps: 0xFFFFFFFE -> 0x00000002 for STAGES=4).
REQ-015 Unstalled latency from input acceptance to out_valid SHALL be STAGES+1 cycles (STAGES stages plus the FIFO write).
REQ-016 The global stall gs SHALL be (last stage valid AND FIFO full AND NOT pop this cycle); when gs is high, all stages SHALL hold.
REQ-017 Bubbles SHALL NOT be compressed: gs freezes the whole lane even if earlier stages are empty.
REQ-018 Skid: an input arriving (in_valid high) while gs is high SHALL be captured into a 1-entry skid register, never dropped.
REQ-019 The stall output SHALL be gs OR skid_valid, driven combinationally from state and out_ready.
REQ-020 When gs falls, stage 0 SHALL load the skid entry before any new input; skid_valid SHALL clear on the same edge.
REQ-021 An input arriving while the skid is full and gs is high SHALL be a protocol violation; the upstream contract forbids it, and an assertion SHALL flag it.
REQ-022 The FIFO SHALL push when the last stage is valid and not gs, and SHALL pop when out_valid AND out_ready; simultaneous push and pop when full SHALL be legal and keep the count constant.
REQ-023 Flush SHALL, on the next edge, clear all stage valids and skid_valid, and SHALL discard the same-cycle input.
REQ-024 Flush SHALL NOT touch FIFO contents, and SHALL have priority over gs and skid load.
REQ-025 Flush in consecutive cycles SHALL keep the lane empty; stall SHALL deassert the cycle after flush unless the FIFO is full with a valid last stage.

Reset
REQ-026 Asserting reset_n low SHALL asynchronously clear all stage valids, skid_valid, and FIFO pointers and count.
REQ-027 During reset, out_valid_1 and out_valid_2 SHALL be 0, stall_1 and stall_2 SHALL be 0, and data registers SHALL be 0.
REQ-028 Reset mid-operation SHALL drop all in-flight and buffered items; the first accepted input after release SHALL appear after STAGES+1 cycles.

Structure
REQ-029 A shared package dsp_pkg SHALL hold the default DATA_W, STAGES and FIFO_DEPTH constants and a lane-state struct (valid, data).
REQ-030 One sub-module, stall_pipe_lane (stages, skid, FIFO, stall logic), SHALL be instantiated twice; the top level is wiring only.

Verification
REQ-031 Lane 1 inputs 0,2,4,6 each cycle with out_ready=1 -> out_data_1 = 4,6,8,10 starting cycle 5, with stall_1 never high.
REQ-032 out_ready_2=0 with continuous lane 2 inputs 1,3,5,... -> the FIFO fills 4 entries, stall_2 rises, the skid captures exactly one item, and no loss; after release the outputs are 5,7,9,... in order with no gaps.
REQ-033 flush_1 pulsed with 3 items in flight and 2 in the FIFO -> exactly 2 items emerge and the in-flight ones are gone; the next input emerges 5 cycles later.
REQ-034 Input 0xFFFFFFFE on lane 1 -> output 0x00000002.
REQ-035 reset_n pulsed low mid-burst with the FIFO half full -> all outputs 0 immediately, and normal latency after release.
REQ-036 Lane 1 stalled while lane 2 is free-running -> lane 2 throughput stays 1 item per cycle and stall_2 stays 0.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants and types for the dual stall pipeline.
// Both lanes and the top level import this package.
package dsp_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_STAGES     = 4;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef struct packed {
      logic                  valid;
      logic [DEF_DATA_W-1:0] data;
   } lane_state_t;

endpackage

// File: rtl/stall_pipe_lane.sv
// One lane: incrementing stages, 1-entry skid, output FIFO.
// The lane freezes as a whole when the FIFO cannot take the last stage.
module stall_pipe_lane
   import dsp_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STAGES     = DEF_STAGES,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              flush,
   output logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [STAGES-1:0] st_v;
   logic [DATA_W-1:0] st_d [STAGES];

   logic              skid_v;
   logic [DATA_W-1:0] skid_d;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic              full;
   logic              pop;
   logic              push;
   logic              gs;
   logic              s0_v;
   logic [DATA_W-1:0] s0_d;

   assign full      = (count == FULL_CNT);
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign gs        = st_v[STAGES-1] & full & ~pop;
   assign push      = st_v[STAGES-1] & ~gs & ~flush;
   assign stall     = gs | skid_v;
   assign out_data  = mem[rd_ptr];

   // Stage 0 source: a held skid entry wins over the live input.
   always_comb begin
      s0_v = in_valid;
      s0_d = in_data;
      if (skid_v) begin
         s0_v = 1'b1;
         s0_d = skid_d;
      end
   end

   // Stage registers: advance together unless frozen; flush drops them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_v <= '0;
         for (int k = 0; k < STAGES; k++)
            st_d[k] <= '0;
      end else if (flush) begin
         st_v <= '0;
      end else if (!gs) begin
         st_v    <= {st_v[STAGES-2:0], s0_v};
         st_d[0] <= s0_d + DATA_W'(1);
         for (int k = 1; k < STAGES; k++)
            st_d[k] <= st_d[k-1] + DATA_W'(1);
      end
   end

   // Skid register: parks one input that arrives while the lane is frozen.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skid_v <= 1'b0;
         skid_d <= '0;
      end else if (flush) begin
         skid_v <= 1'b0;
      end else if (gs) begin
         if (in_valid && !skid_v) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
         end
      end else if (skid_v) begin
         skid_v <= in_valid;
         skid_d <= in_data;
      end
   end

   // Output FIFO: push from the last stage, pop on downstream ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++)
            mem[k] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= st_d[STAGES-1];
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   a_skid_overflow: assert property (
      @(posedge clk) disable iff (!reset_n)
      !(in_valid && gs && skid_v && !flush));

endmodule

// File: rtl/dual_stall_pipeline.sv
// Two independent stall-aware incrementing lanes.
// Top level only wires the two lane instances.
module dual_stall_pipeline
   import dsp_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STAGES     = DEF_STAGES,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] pipeline1_inputs,
   input  logic [DATA_W-1:0] pipeline2_inputs,
   input  logic [1:0]        in_valid,
   input  logic              flush_1,
   input  logic              flush_2,
   output logic              stall_1,
   output logic              stall_2,
   output logic              out_valid_1,
   output logic              out_valid_2,
   output logic [DATA_W-1:0] out_data_1,
   output logic [DATA_W-1:0] out_data_2,
   input  logic              out_ready_1,
   input  logic              out_ready_2
);

   stall_pipe_lane #(
      .DATA_W     (DATA_W),
      .STAGES     (STAGES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_lane1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (pipeline1_inputs),
      .in_valid  (in_valid[0]),
      .flush     (flush_1),
      .stall     (stall_1),
      .out_valid (out_valid_1),
      .out_data  (out_data_1),
      .out_ready (out_ready_1)
   );

   stall_pipe_lane #(
      .DATA_W     (DATA_W),
      .STAGES     (STAGES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_lane2 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (pipeline2_inputs),
      .in_valid  (in_valid[1]),
      .flush     (flush_2),
      .stall     (stall_2),
      .out_valid (out_valid_2),
      .out_data  (out_data_2),
      .out_ready (out_ready_2)
   );

endmodule

// File: tb/tb_dual_stall_pipeline.sv
// Directed bench for dual_stall_pipeline (STAGES=4, FIFO_DEPTH=4).
// Upstream model reacts to stall one cycle late, exercising the skid.
module tb_dual_stall_pipeline;
   import dsp_pkg::*;

   localparam int W = DEF_DATA_W;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] p1, p2;
   logic [1:0]   in_valid;
   logic         flush_1, flush_2;
   logic         stall_1, stall_2;
   logic         ov1, ov2;
   logic [W-1:0] od1, od2;
   logic         or1, or2;

   int checks = 0;
   int errors = 0;

   lane_state_t mon;
   logic        sp;
   logic [W-1:0] nv;
   int          acc;

   always #5 clk = ~clk;

   dual_stall_pipeline #(
      .DATA_W     (W),
      .STAGES     (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .pipeline1_inputs (p1),
      .pipeline2_inputs (p2),
      .in_valid         (in_valid),
      .flush_1          (flush_1),
      .flush_2          (flush_2),
      .stall_1          (stall_1),
      .stall_2          (stall_2),
      .out_valid_1      (ov1),
      .out_valid_2      (ov2),
      .out_data_1       (od1),
      .out_data_2       (od2),
      .out_ready_1      (or1),
      .out_ready_2      (or2)
   );

   task automatic chk(input string tag,
                      input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n  = 1'b0;
      p1       = '0;
      p2       = '0;
      in_valid = 2'b00;
      flush_1  = 1'b0;
      flush_2  = 1'b0;
      or1      = 1'b1;
      or2      = 1'b1;

      // reset state
      tick();
      tick();
      chk("rst_ov1", ov1, 1'b0);
      chk("rst_ov2", ov2, 1'b0);
      chk("rst_st1", stall_1, 1'b0);
      chk("rst_st2", stall_2, 1'b0);
      chk("rst_od1", od1, '0);
      chk("rst_od2", od2, '0);
      reset_n = 1'b1;

      // lane 1 streaming 0,2,4,6 -> 4,6,8,10 from cycle 5
      for (int c = 0; c < 10; c++) begin
         in_valid[0] = (c < 4);
         p1 = W'(2 * c);
         #1;
         chk("str_stall1", stall_1, 1'b0);
         if (c < 5 || c > 8) begin
            chk("str_ov_lo", ov1, 1'b0);
         end else begin
            chk("str_ov_hi", ov1, 1'b1);
            chk("str_data", od1, W'(4 + 2 * (c - 5)));
         end
         tick();
      end

      // wrap-around
      in_valid[0] = 1'b1;
      p1 = 32'hFFFF_FFFE;
      tick();
      in_valid[0] = 1'b0;
      repeat (4) tick();
      #1;
      chk("wrap_ov", ov1, 1'b1);
      chk("wrap_data", od1, 32'h0000_0002);
      tick();

      // lane 2 back-pressure, skid capture, lossless drain
      or2 = 1'b0;
      sp  = 1'b0;
      nv  = 1;
      acc = 0;
      for (int c = 0; c < 13; c++) begin
         if (!sp) begin
            in_valid[1] = 1'b1;
            p2 = nv;
            nv = nv + 2;
            acc++;
         end else begin
            in_valid[1] = 1'b0;
         end
         #1;
         if (c == 7) chk("bp_stall_lo", stall_2, 1'b0);
         if (c >= 8) chk("bp_stall_hi", stall_2, 1'b1);
         sp = stall_2;
         tick();
      end
      in_valid[1] = 1'b0;
      chk("bp_accepted", W'(acc), W'(9));
      #1;
      chk("bp_head_ov", ov2, 1'b1);
      chk("bp_head", od2, W'(5));
      or2 = 1'b1;
      for (int k = 0; k < 9; k++) begin
         #1;
         mon = '{valid: ov2, data: od2};
         chk("drain_ov", mon.valid, 1'b1);
         chk("drain_data", mon.data, W'(5 + 2 * k));
         tick();
      end
      #1;
      chk("drain_empty", ov2, 1'b0);
      tick();

      // flush with 3 in flight and 2 in the FIFO
      for (int c = 0; c < 13; c++) begin
         in_valid[0] = (c < 5) || (c == 6);
         p1 = (c == 6) ? W'(99) : W'(10 * (c + 1));
         flush_1 = (c == 6);
         or1 = (c >= 7);
         #1;
         if (c == 6) chk("fl_stall", stall_1, 1'b0);
         if (c == 7) begin
            chk("fl_ov0", ov1, 1'b1);
            chk("fl_d0", od1, W'(14));
            chk("fl_stall_after", stall_1, 1'b0);
         end
         if (c == 8) begin
            chk("fl_ov1", ov1, 1'b1);
            chk("fl_d1", od1, W'(24));
         end
         if (c >= 9) chk("fl_gone", ov1, 1'b0);
         tick();
      end
      flush_1 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid[0] = (c == 0);
         p1 = W'(60);
         #1;
         if (c < 5) begin
            chk("fl_lat_lo", ov1, 1'b0);
         end else begin
            chk("fl_lat_ov", ov1, 1'b1);
            chk("fl_lat_d", od1, W'(64));
         end
         tick();
      end
      in_valid[0] = 1'b0;
      tick();

      // lane 1 stalled, lane 2 free-running
      or1 = 1'b0;
      or2 = 1'b1;
      sp  = 1'b0;
      nv  = 200;
      for (int c = 0; c < 20; c++) begin
         if (!sp) begin
            in_valid[0] = 1'b1;
            p1 = nv;
            nv = nv + 1;
         end else begin
            in_valid[0] = 1'b0;
         end
         in_valid[1] = (c < 12);
         p2 = W'(100 + c);
         #1;
         chk("ind_stall2", stall_2, 1'b0);
         if (c >= 5 && c < 17) begin
            chk("ind_ov2", ov2, 1'b1);
            chk("ind_d2", od2, W'(104 + c - 5));
         end
         sp = stall_1;
         tick();
      end
      in_valid = 2'b00;
      #1;
      chk("ind_stall1", stall_1, 1'b1);

      // reset mid-burst with lane 1 FIFO half full
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      tick();
      or1 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid[0] = 1'b1;
         p1 = W'(300 + c);
         tick();
      end
      in_valid[0] = 1'b0;
      #1;
      chk("mr_pre_ov", ov1, 1'b1);
      chk("mr_pre_d", od1, W'(304));
      reset_n = 1'b0;
      #1;
      chk("mr_ov1", ov1, 1'b0);
      chk("mr_ov2", ov2, 1'b0);
      chk("mr_st1", stall_1, 1'b0);
      chk("mr_st2", stall_2, 1'b0);
      chk("mr_od1", od1, '0);
      chk("mr_od2", od2, '0);
      tick();
      reset_n = 1'b1;
      or1 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         in_valid[0] = (c == 0);
         p1 = W'(500);
         #1;
         if (c < 5) begin
            chk("mr_lat_lo", ov1, 1'b0);
         end else begin
            chk("mr_lat_ov", ov1, 1'b1);
            chk("mr_lat_d", od1, W'(504));
         end
         tick();
      end
      in_valid = 2'b00;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
